// File: rtl/multicycle_add_sub.sv
// Multi-cycle ripple adder/subtractor: WIDTH bits processed CHUNK bits
// per clock, LSB chunk first, with carry held in a register between chunks.
module multicycle_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   csum;
    logic             msb_cin;
    logic             last;

    // Current chunk slice and its sum; b_q already holds the effective B
    assign a_chunk = a_q[k_q*CHUNK +: CHUNK];
    assign b_chunk = b_q[k_q*CHUNK +: CHUNK];
    assign csum    = {1'b0, a_chunk} + {1'b0, b_chunk}
                   + {{CHUNK{1'b0}}, carry_q};
    assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ csum[CHUNK-1];
    assign last    = (k_q == KW'(NCHUNK - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE accepts start, RUN ends after the last chunk
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: busy follows the RUN state directly
    always_comb begin
        busy = (state_q == RUN);
    end

    // Datapath next state: operand capture, chunk step and completion
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        k_d        = k_q;
        shadow_d   = shadow_q;
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    k_d     = '0;
                end
            end
            RUN: begin
                shadow_d[k_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
                carry_d = csum[CHUNK];
                k_d     = k_q + KW'(1);
                if (last) begin
                    result_d   = shadow_d;
                    cout_d     = csum[CHUNK];
                    overflow_d = msb_cin ^ csum[CHUNK];
                    zero_d     = (shadow_d == '0);
                    done_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears visible outputs and drops work
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            k_q        <= '0;
            shadow_q   <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            k_q        <= k_d;
            shadow_q   <= shadow_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
        end
    end

    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_multicycle_add_sub.sv
// Bench for multicycle_add_sub: CHUNK=8 directed tests plus CHUNK=1 and
// CHUNK=32 random sweeps, all scored against a queue of model results.
module tb_multicycle_add_sub;

    localparam int W   = 32;
    localparam int C8  = 8;
    localparam int C1  = 1;
    localparam int C32 = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, sub, cin;
    logic [W-1:0] a, b;
    logic         st8, st1, st32;
    logic         busy8, done8, co8, ov8, z8;
    logic         busy1, done1, co1, ov1, z1;
    logic         busy32, done32, co32, ov32, z32;
    logic [W-1:0] r8, r1, r32;

    multicycle_add_sub #(.WIDTH(W), .CHUNK(C8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy8), .done(done8), .result(r8),
        .cout(co8), .overflow(ov8), .zero(z8)
    );

    multicycle_add_sub #(.WIDTH(W), .CHUNK(C1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy1), .done(done1), .result(r1),
        .cout(co1), .overflow(ov1), .zero(z1)
    );

    multicycle_add_sub #(.WIDTH(W), .CHUNK(C32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy32), .done(done32), .result(r32),
        .cout(co32), .overflow(ov32), .zero(z32)
    );

    initial begin
        if ((W % C8) != 0 || (W % C1) != 0 || (W % C32) != 0) begin
            $display("FAIL param: WIDTH not a multiple of CHUNK");
            $fatal(1, "bad parameters");
        end
    end

    typedef struct {
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        logic         z;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        logic         z;
    } vec_t;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q32[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic c);
        logic [W:0]   t;
        logic [W-1:0] be;
        logic         ci;
        exp_t         e;
        be   = s ? ~y : y;
        ci   = s ? 1'b1 : c;
        t    = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, ci};
        e.r  = t[W-1:0];
        e.co = t[W];
        e.ov = (x[W-1] == be[W-1]) && (e.r[W-1] != x[W-1]);
        e.z  = (e.r == '0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chkres(input string tag, input exp_t e,
                          input logic [W-1:0] r, input logic co,
                          input logic ov, input logic z);
        chk({tag, "_result"}, r, e.r);
        chk({tag, "_cout"}, co, e.co);
        chk({tag, "_ovf"}, ov, e.ov);
        chk({tag, "_zero"}, z, e.z);
    endtask

    task automatic spurious(input string tag);
        total++;
        bad++;
        $display("FAIL %s_spurious_done: done with no pending op", tag);
    endtask

    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            if (q8.size() == 0) spurious("u8");
            else begin
                e = q8.pop_front();
                chkres("u8", e, r8, co8, ov8, z8);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n === 1'b1 && done1 === 1'b1) begin
            if (q1.size() == 0) spurious("u1");
            else begin
                e = q1.pop_front();
                chkres("u1", e, r1, co1, ov1, z1);
            end
        end
    end

    always @(negedge clk) begin : mon32
        exp_t e;
        if (rst_n === 1'b1 && done32 === 1'b1) begin
            if (q32.size() == 0) spurious("u32");
            else begin
                e = q32.pop_front();
                chkres("u32", e, r32, co32, ov32, z32);
            end
        end
    end

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done8 : (sel == 1) ? done1 : done32;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy8 : (sel == 1) ? busy1 : busy32;
    endfunction

    function automatic logic [W-1:0] get_res(input int sel);
        return (sel == 0) ? r8 : (sel == 1) ? r1 : r32;
    endfunction

    task automatic set_st(input int sel, input logic v);
        if (sel == 0) st8 = v;
        else if (sel == 1) st1 = v;
        else st32 = v;
    endtask

    // Drive one op at a negedge, push expectation, measure latency/busy.
    task automatic run_op(input int sel, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic s,
                          input logic c, input exp_t e, input bit inj,
                          input bit hold_en, input logic [W-1:0] held,
                          input string nm);
        int   n;
        int   nch;
        logic bb;
        logic hb;
        nch = (sel == 0) ? W / C8 : (sel == 1) ? W / C1 : W / C32;
        a   = x;
        b   = y;
        sub = s;
        cin = c;
        if (sel == 0) q8.push_back(e);
        else if (sel == 1) q1.push_back(e);
        else q32.push_back(e);
        set_st(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_st(sel, 1'b0);
        n  = 0;
        bb = 1'b0;
        hb = 1'b0;
        while (n < 200) begin
            if (get_done(sel)) break;
            if (!get_busy(sel)) bb = 1'b1;
            if (hold_en && get_res(sel) !== held) hb = 1'b1;
            if (inj && n == 2) begin
                a   = ~x;
                b   = x ^ y;
                sub = ~s;
                set_st(sel, 1'b1);
            end else if (inj && n == 3) begin
                set_st(sel, 1'b0);
            end
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, nch);
        chk({nm, "_busy_low_in_run"}, bb, 1'b0);
        chk({nm, "_busy_at_done"}, get_busy(sel), 1'b0);
        if (hold_en) chk({nm, "_held"}, hb, 1'b0);
    endtask

    vec_t tbl[8];
    exp_t ex;

    initial begin
        tbl[0] = '{32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{32'h3, 32'h5, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{32'h5, 32'h7, 1'b0, 1'b1, 32'hD, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'hA, 32'hA, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{32'h64, 32'h1, 1'b1, 1'b1, 32'h63, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        st8   = 1'b1;
        st1   = 1'b1;
        st32  = 1'b1;
        sub   = 1'b0;
        cin   = 1'b1;
        a     = 32'h12345678;
        b     = 32'h9ABCDEF0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_result", r8, 32'h0);
        chk("rst_cout", co8, 1'b0);
        chk("rst_ovf", ov8, 1'b0);
        chk("rst_zero", z8, 1'b0);
        chk("rst_busy1", busy1, 1'b0);
        rst_n = 1'b1;
        st8   = 1'b0;
        st1   = 1'b0;
        st32  = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy8, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ex = '{tbl[i].r, tbl[i].co, tbl[i].ov, tbl[i].z};
            run_op(0, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, ex,
                   1'b0, 1'b0, '0, $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), done8, 1'b0);
        end

        run_op(0, 32'h1, 32'h2, 1'b0, 1'b0, model(32'h1, 32'h2, 1'b0, 1'b0),
               1'b1, 1'b0, '0, "ignore_start");
        @(negedge clk);
        chk("ignore_start_not_queued", busy8, 1'b0);
        chk("ignore_start_result_kept", r8, 32'h3);

        run_op(0, 32'h3, 32'h5, 1'b1, 1'b0, model(32'h3, 32'h5, 1'b1, 1'b0),
               1'b0, 1'b0, '0, "b2b_first");
        run_op(0, 32'h5, 32'h7, 1'b0, 1'b1, model(32'h5, 32'h7, 1'b0, 1'b1),
               1'b0, 1'b1, 32'hFFFFFFFE, "b2b_second");
        chk("b2b_result", r8, 32'hD);

        a   = 32'hAAAAAAAA;
        b   = 32'h55555555;
        sub = 1'b0;
        cin = 1'b1;
        st8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0;
        repeat (2) @(negedge clk);
        q8.delete();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", busy8, 1'b0);
        chk("midrst_done", done8, 1'b0);
        chk("midrst_result", r8, 32'h0);
        chk("midrst_flags", {co8, ov8, z8}, 3'b000);
        repeat (6) @(negedge clk);
        chk("midrst_stays_idle", busy8, 1'b0);
        run_op(0, 32'd10, 32'd20, 1'b0, 1'b0,
               model(32'd10, 32'd20, 1'b0, 1'b0), 1'b0, 1'b0, '0, "after_rst");
        chk("after_rst_result", r8, 32'd30);

        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic         s;
            logic         c;
            x = $urandom;
            y = $urandom;
            s = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            if (i % 50 == 0) y = (s) ? x : ~x;
            run_op(1, x, y, s, c, model(x, y, s, c), 1'b0, 1'b0, '0, "sweep1");
            run_op(2, x, y, s, c, model(x, y, s, c), 1'b0, 1'b0, '0, "sweep32");
        end

        repeat (3) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q32_drained", q32.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_add_sub.md
Name: multicycle_add_sub

Overview:
- Parametrised, multi-cycle ripple adder/subtractor that succeeds the single-bit full adder cell in the ALU datapath.
- Processes a WIDTH-bit operation CHUNK bits per clock, LSB chunk first, carrying between chunks in a register.
- Uses a start/busy/done handshake, so the ALU can trade latency for area.
- Produces the result plus carry, signed-overflow and zero flags for the status logic.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits added per clock cycle (1..WIDTH). NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a new operation; sampled only when idle.
- sub  input  1  0 = add, 1 = subtract; captured with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when result and flags are valid.
- result  output  WIDTH  sum/difference; held until the next completion.
- cout  output  1  final carry out (sub: 1 = no borrow).
- overflow  output  1  two's-complement overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All outputs go to 0: busy, done, result, cout, overflow, zero.
  - The FSM goes to IDLE and the chunk counter clears.
  - Reset overrides everything, including mid-operation. The partial result is discarded and no done pulse is produced.
- State IDLE:
  - start=1 at an edge latches a, b, sub and cin.
  - The effective B is b when sub=0 and ~b when sub=1.
  - The carry register loads cin when sub=0 and 1 when sub=1.
  - The chunk index clears to 0, the FSM goes to RUN, and busy=1 from the next cycle.
- State RUN: each edge performs one step.
  - Add chunk k of A, chunk k of effective B and the carry register.
  - Write the CHUNK sum bits into result-shadow bits [k*CHUNK +: CHUNK].
  - Update the carry register with the chunk carry-out.
  - Increment k.
  - On the edge that processes chunk NCHUNK-1:
    - result <= completed shadow.
    - cout <= final carry.
    - overflow <= carry into MSB XOR carry out of MSB.
    - zero <= (completed result == 0).
    - done <= 1, busy <= 0, and the FSM returns to IDLE.
- Latency: with start sampled at edge t0, done is high during the cycle after edge t0+NCHUNK, so it is visible NCHUNK cycles after start. Throughput is one operation per NCHUNK+1 cycles maximum.
- done is high for exactly one cycle. It is cleared on the next edge unless another completion occurs.
- start while busy=1 is ignored: no queueing and no corruption of the in-flight operation. Operand changes during RUN have no effect.
- start may be asserted in the cycle where done=1 (FSM is IDLE). It is accepted, giving back-to-back operation.
- result and the flags are stable from completion until the next completion or reset. They do not change during a subsequent RUN.
- Arithmetic is modulo 2^WIDTH with no saturation.
- For sub: result = a - b, and cout = 1 when a >= b unsigned.
- CHUNK=WIDTH degenerates to a 1-cycle RUN. CHUNK=1 is fully bit-serial (WIDTH cycles). Both must work.
- Behaviour is undefined if WIDTH % CHUNK != 0. The block must not be instantiated that way; the bench must check this with a parameter assertion.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, result=0, cout=overflow=zero=0, and no operation starts.
- Add wrap, WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> done exactly 4 cycles after the start edge with result=0x00000000, cout=1, zero=1, overflow=0. busy=1 for the 4 cycles in between.
- Signed overflow:
  - Add a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1, cout=0.
  - Sub a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1, cout=1.
  - Sub a=3, b=5 -> result=0xFFFFFFFE, cout=0, overflow=0.
- Handshake:
  - Pulse start again 2 cycles into an operation with different operands -> ignored, and the first result is unchanged.
  - Assert start with a=5, b=7, sub=0, cin=1 in the done cycle -> accepted, and the next done gives result=13 with the previous result held in the meantime.
- Reset mid-operation: drop rst_n for 1 cycle at RUN chunk 2 -> no done pulse and all outputs 0. A following start of a=10, b=20 gives result=30 after 4 cycles.
- Parameter sweep: CHUNK=1 (latency 32) and CHUNK=32 (latency 1) against 1000 random a/b/sub/cin vectors -> result, cout, overflow and zero match the reference model, and latency equals NCHUNK every time.
